// File: rtl/hazard_pkg.sv
// Shared forwarding select codes and pipeline slot record for the hazard unit and the EX stage.
package hazard_pkg;

    localparam logic [2:0] FWD_IDEX  = 3'b001;
    localparam logic [2:0] FWD_EXMEM = 3'b010;
    localparam logic [2:0] FWD_MEMWB = 3'b100;

    // Slot register addresses are held at this width; narrower REG_AW values are zero-extended.
    localparam int unsigned MAX_REG_AW = 8;

    typedef logic [MAX_REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t dest;
        logic      reg_write;
        logic      mem_read;
    } slot_t;

    // allow_load = 0 excludes loads, whose data is not yet available while they sit in EX.
    function automatic logic writer_hit(input slot_t s, input reg_addr_t src, input logic allow_load);
        return s.valid && s.reg_write && (s.dest == src) && (src != '0) && (allow_load || !s.mem_read);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority comparator choosing the operand source for one ID register operand.
module fwd_select
    import hazard_pkg::*;
(
    input  reg_addr_t  src,
    input  logic       uses,
    input  slot_t      ex_slot,
    input  slot_t      mem_slot,
    output logic [2:0] code
);

    always_comb begin
        code = FWD_IDEX;
        if (uses) begin
            if (writer_hit(ex_slot, src, 1'b0)) begin
                code = FWD_EXMEM;
            end else if (writer_hit(mem_slot, src, 1'b1)) begin
                code = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Tracks in-flight destinations, registers EX operand forwarding codes and raises load-use stalls.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [2:0]        fwdA,
    output logic [2:0]        fwdB,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    reg_addr_t        rs_x;
    reg_addr_t        rt_x;
    slot_t            ex_d, ex_q;
    slot_t            mem_d, mem_q;
    logic [2:0]       sel_a, sel_b;
    logic [2:0]       fwd_a_d, fwd_a_q;
    logic [2:0]       fwd_b_d, fwd_b_q;
    logic [CNT_W-1:0] stall_count_d, stall_count_q;

    assign rs_x = reg_addr_t'(id_rs);
    assign rt_x = reg_addr_t'(id_rt);

    fwd_select u_sel_rs (
        .src      (rs_x),
        .uses     (id_uses_rs),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .code     (sel_a)
    );

    fwd_select u_sel_rt (
        .src      (rt_x),
        .uses     (id_uses_rt),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .code     (sel_b)
    );

    always_comb begin
        stall = id_valid && !flush && ex_q.mem_read &&
                ((id_uses_rs && writer_hit(ex_q, rs_x, 1'b1)) ||
                 (id_uses_rt && writer_hit(ex_q, rt_x, 1'b1)));
    end

    // No WB shadow is kept: the register file writes first, so a WB producer never forwards.
    always_comb begin
        mem_d = ex_q;
        ex_d  = '0;
        if (!flush && !stall) begin
            ex_d.valid     = id_valid;
            ex_d.dest      = reg_addr_t'(id_dest);
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end
        fwd_a_d = ex_d.valid ? sel_a : FWD_IDEX;
        fwd_b_d = ex_d.valid ? sel_b : FWD_IDEX;
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q          <= '0;
            mem_q         <= '0;
            fwd_a_q       <= FWD_IDEX;
            fwd_b_q       <= FWD_IDEX;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fwdA        = fwd_a_q;
    assign fwdB        = fwd_b_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed pipeline scenarios plus random traffic against an in-flight queue model.
module tb_hazard_forward_unit;

    localparam int TB_REG_AW = 5;
    localparam int TB_CNT_W  = 10;
    localparam int CNT_MAX   = (1 << TB_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 id_valid;
    logic [TB_REG_AW-1:0] id_rs, id_rt, id_dest;
    logic                 id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic                 flush;
    logic [2:0]           fwdA, fwdB;
    logic                 stall;
    logic [TB_CNT_W-1:0]  stall_count;

    int checks   = 0;
    int failures = 0;

    hazard_forward_unit #(.REG_AW(TB_REG_AW), .CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwdA         (fwdA),
        .fwdB         (fwdB),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the two most recently issued instructions, newest first (EX, then MEM).
    typedef struct {
        bit v;
        int dest;
        bit rw;
        bit ld;
    } ent_t;

    ent_t inflight[$];
    bit   model_ok = 0;
    int   m_fwd_a, m_fwd_b, m_cnt;

    function automatic int exp_code(input int src, input bit uses);
        if (!uses || src == 0) return 1;
        for (int i = 0; i < 2; i++) begin
            if (inflight[i].v && inflight[i].rw && inflight[i].dest == src)
                return (i == 0) ? 2 : 4;
        end
        return 1;
    endfunction

    always @(negedge clk) begin
        ent_t e;
        bit   exp_stall;
        if (model_ok) begin
            exp_stall = id_valid && !flush && inflight[0].v && inflight[0].rw && inflight[0].ld &&
                        inflight[0].dest != 0 &&
                        ((id_uses_rs && int'(id_rs) == inflight[0].dest) ||
                         (id_uses_rt && int'(id_rt) == inflight[0].dest));
            check("mon_stall", int'(stall), int'(exp_stall));
            check("mon_fwdA", int'(fwdA), m_fwd_a);
            check("mon_fwdB", int'(fwdB), m_fwd_b);
            check("mon_count", int'(stall_count), m_cnt);
        end else begin
            exp_stall = 0;
        end
        if (rst) begin
            e = '{v: 0, dest: 0, rw: 0, ld: 0};
            inflight = {e, e};
            m_fwd_a = 1;
            m_fwd_b = 1;
            m_cnt = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (flush || exp_stall || !id_valid) begin
                e = '{v: 0, dest: 0, rw: 0, ld: 0};
                m_fwd_a = 1;
                m_fwd_b = 1;
            end else begin
                e = '{v: 1, dest: int'(id_dest), rw: id_reg_write, ld: id_mem_read};
                m_fwd_a = exp_code(int'(id_rs), id_uses_rs);
                m_fwd_b = exp_code(int'(id_rt), id_uses_rt);
            end
            if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
            inflight.push_front(e);
            void'(inflight.pop_back());
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input int dest, input bit rw, input bit ld);
        id_valid     = v;
        id_rs        = TB_REG_AW'(rs);
        id_rt        = TB_REG_AW'(rt);
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_dest      = TB_REG_AW'(dest);
        id_reg_write = rw;
        id_mem_read  = ld;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        flush = 0;
        step();
        step();
    endtask

    initial begin
        rst = 1;
        flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 0;
        #1;
        check("reset_fwdA", int'(fwdA), 1);
        check("reset_fwdB", int'(fwdB), 1);
        check("reset_count", int'(stall_count), 0);
        check("reset_stall", int'(stall), 0);

        // add $3,$1,$2 ; sub $5,$3,$4
        set_id(1, 1, 2, 1, 1, 3, 1, 0); step();
        set_id(1, 3, 4, 1, 1, 5, 1, 0); #1;
        check("alu_dep_stall", int'(stall), 0);
        step();
        check("alu_dep_fwdA", int'(fwdA), 2);
        check("alu_dep_fwdB", int'(fwdB), 1);

        // add $3 ; unrelated ; or $6,$0,$3
        drain();
        set_id(1, 1, 2, 1, 1, 3, 1, 0); step();
        set_id(1, 9, 10, 1, 1, 8, 1, 0); step();
        set_id(1, 0, 3, 1, 1, 6, 1, 0); step();
        check("memwb_fwdA", int'(fwdA), 1);
        check("memwb_fwdB", int'(fwdB), 4);

        // lw $4,0($1) ; add $7,$4,$4
        drain();
        set_id(1, 1, 4, 1, 0, 4, 1, 1); step();
        set_id(1, 4, 4, 1, 1, 7, 1, 0); #1;
        check("loaduse_stall", int'(stall), 1);
        check("loaduse_count0", int'(stall_count), 0);
        step();
        check("loaduse_stall_drop", int'(stall), 0);
        check("loaduse_count1", int'(stall_count), 1);
        step();
        check("loaduse_fwdA", int'(fwdA), 4);
        check("loaduse_fwdB", int'(fwdB), 4);

        // add $0,$1,$2 ; sub $5,$0,$0, then lw $0 ; use $0
        drain();
        set_id(1, 1, 2, 1, 1, 0, 1, 0); step();
        set_id(1, 0, 0, 1, 1, 5, 1, 0); #1;
        check("zero_stall", int'(stall), 0);
        step();
        check("zero_fwdA", int'(fwdA), 1);
        check("zero_fwdB", int'(fwdB), 1);
        set_id(1, 1, 0, 1, 0, 0, 1, 1); step();
        set_id(1, 0, 0, 1, 1, 5, 1, 0); #1;
        check("zero_load_stall", int'(stall), 0);

        // Two writers of $3 in flight: EX/MEM has priority
        drain();
        set_id(1, 1, 2, 1, 1, 3, 1, 0); step();
        set_id(1, 5, 6, 1, 1, 3, 1, 0); step();
        set_id(1, 3, 3, 1, 1, 9, 1, 0); step();
        check("prio_fwdA", int'(fwdA), 2);
        check("prio_fwdB", int'(fwdB), 2);

        // Load-use coinciding with flush
        drain();
        set_id(1, 1, 4, 1, 0, 4, 1, 1); step();
        set_id(1, 4, 4, 1, 1, 7, 1, 0);
        flush = 1; #1;
        check("flush_stall", int'(stall), 0);
        step();
        flush = 0;
        check("flush_fwdA", int'(fwdA), 1);
        check("flush_fwdB", int'(fwdB), 1);
        check("flush_count", int'(stall_count), 1);

        // Reset pulsed while stalled
        drain();
        set_id(1, 1, 4, 1, 0, 4, 1, 1); step();
        set_id(1, 4, 4, 1, 1, 7, 1, 0); #1;
        check("rststall_stall", int'(stall), 1);
        rst = 1;
        step();
        rst = 0;
        #1;
        check("rststall_count", int'(stall_count), 0);
        check("rststall_fwdA", int'(fwdA), 1);
        check("rststall_fwdB", int'(fwdB), 1);
        check("rststall_stall_after", int'(stall), 0);

        // Saturation: lw $4,0($4) repeated stalls every other cycle
        drain();
        set_id(1, 4, 4, 1, 0, 4, 1, 1);
        for (int i = 0; i < 2 * ((1 << TB_CNT_W) + 4); i++) step();
        check("sat_count", int'(stall_count), CNT_MAX);

        // Random traffic checked by the monitor
        rst = 1; drain(); rst = 0;
        for (int i = 0; i < 1500; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
